// File: rtl/regfile_wport_arb.sv
// -----------------------------------------------------------------------------
// regfile_wport_arb
//
// Write-port controller for a 2^AW x XLEN integer register file (x0 reads as
// zero, reads are combinational, one write port). Two writeback requesters
// share the write port under round-robin arbitration. The granted write is
// registered onto the register file's write enable/address/data. A per-register
// pending scoreboard lets issue logic stall on read-after-write hazards.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req0_valid/ready/addr/data   requester 0 (ALU/jump result)
//   req1_valid/ready/addr/data   requester 1 (load return)
//   rf_write, rf_wa, rf_wd   registered register-file write port
//   sb_set, sb_addr          mark a destination register pending at issue
//   chk_ra1, chk_ra2         source registers of the instruction being issued
//   hazard                   a checked source register is pending (comb.)
//   busy                     scoreboard vector, bit 0 always 0
// -----------------------------------------------------------------------------
module regfile_wport_arb #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [AW-1:0]        req0_addr,
    input  logic [XLEN-1:0]      req0_data,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [AW-1:0]        req1_addr,
    input  logic [XLEN-1:0]      req1_data,
    output logic                 rf_write,
    output logic [AW-1:0]        rf_wa,
    output logic [XLEN-1:0]      rf_wd,
    input  logic                 sb_set,
    input  logic [AW-1:0]        sb_addr,
    input  logic [AW-1:0]        chk_ra1,
    input  logic [AW-1:0]        chk_ra2,
    output logic                 hazard,
    output logic [(1<<AW)-1:0]   busy
);

    localparam int NREG = 1 << AW;

    // Round-robin pointer: index of the requester granted most recently.
    logic            last_q, last_d;
    logic            rf_write_q, rf_write_d;
    logic [AW-1:0]   rf_wa_q, rf_wa_d;
    logic [XLEN-1:0] rf_wd_q, rf_wd_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic grant0;
    logic grant1;

    // Arbitration: uses only valids and the pointer, so ready never depends on
    // addr/data. On contention the requester that did not win last time wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_q;
            grant1 = ~last_q;
        end else if (req0_valid) begin
            grant0 = 1'b1;
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end else begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    // Next state for pointer and output stage. A write to x0 is consumed but
    // never asserts rf_write; without a grant the address/data simply hold.
    always_comb begin
        last_d     = last_q;
        rf_write_d = 1'b0;
        rf_wa_d    = rf_wa_q;
        rf_wd_d    = rf_wd_q;
        if (grant0) begin
            last_d     = 1'b0;
            rf_write_d = (req0_addr != {AW{1'b0}});
            rf_wa_d    = req0_addr;
            rf_wd_d    = req0_data;
        end else if (grant1) begin
            last_d     = 1'b1;
            rf_write_d = (req1_addr != {AW{1'b0}});
            rf_wa_d    = req1_addr;
            rf_wd_d    = req1_data;
        end else begin
            last_d     = last_q;
            rf_write_d = 1'b0;
        end
    end

    // Scoreboard next state. The clear comes from the registered write that the
    // file commits on this same edge; the set is applied afterwards so a newer
    // producer issued on the same edge keeps the register pending.
    always_comb begin
        busy_d = busy_q;
        if (rf_write_q) begin
            busy_d[rf_wa_q] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (sb_set && (sb_addr != {AW{1'b0}})) begin
            busy_d[sb_addr] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // State registers; reset has priority and drops any loaded write.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= 1'b1;
            rf_write_q <= 1'b0;
            rf_wa_q    <= {AW{1'b0}};
            rf_wd_q    <= {XLEN{1'b0}};
            busy_q     <= {NREG{1'b0}};
        end else begin
            last_q     <= last_d;
            rf_write_q <= rf_write_d;
            rf_wa_q    <= rf_wa_d;
            rf_wd_q    <= rf_wd_d;
            busy_q     <= busy_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rf_write   = rf_write_q;
    assign rf_wa      = rf_wa_q;
    assign rf_wd      = rf_wd_q;
    assign busy       = busy_q;

    // x0 is never marked busy, so its bit alone makes the source check safe;
    // the explicit non-zero test keeps the intent obvious.
    assign hazard = ((chk_ra1 != {AW{1'b0}}) & busy_q[chk_ra1]) |
                    ((chk_ra2 != {AW{1'b0}}) & busy_q[chk_ra2]);

endmodule

// File: tb/tb_regfile_wport_arb.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_wport_arb: directed scenarios followed by randomized
// traffic. A driver computes expected grants, scoreboard contents and hazard
// from a behavioural model and pushes expected register-file writes into a
// queue; a separate monitor pops them when the write port is due.
// -----------------------------------------------------------------------------
module tb_regfile_wport_arb;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [AW-1:0]   req0_addr, req1_addr;
    logic [XLEN-1:0] req0_data, req1_data;
    logic            rf_write;
    logic [AW-1:0]   rf_wa;
    logic [XLEN-1:0] rf_wd;
    logic            sb_set;
    logic [AW-1:0]   sb_addr, chk_ra1, chk_ra2;
    logic            hazard;
    logic [31:0]     busy;

    regfile_wport_arb #(.XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .rf_write(rf_write), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .chk_ra1(chk_ra1), .chk_ra2(chk_ra2),
        .hazard(hazard), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) cyc++;

    typedef struct {
        int          due;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    // Behavioural model state
    int          m_last;      // requester granted most recently
    bit          m_busy[32];  // registers with a producer in flight
    int          m_pend_clr;  // register committed at the coming edge (0 = none)
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        m_last     = 1;
        m_pend_clr = 0;
        m_wa       = 5'd0;
        m_wd       = 32'd0;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle: drive inputs after a falling edge, check the
    // combinational and held outputs, advance the model across the next rising
    // edge, then wait for the following falling edge.
    task automatic step(input bit r,
                        input bit v0, input int a0, input logic [31:0] d0,
                        input bit v1, input int a1, input logic [31:0] d1,
                        input bit ss, input int sa, input int ra1, input int ra2,
                        output int g);
        bit exp_hz;
        req0_valid = v0; req0_addr = a0[4:0]; req0_data = d0;
        req1_valid = v1; req1_addr = a1[4:0]; req1_data = d1;
        sb_set = ss; sb_addr = sa[4:0]; chk_ra1 = ra1[4:0]; chk_ra2 = ra2[4:0];
        rst = r;
        #1;
        if (v0 && v1)  g = (m_last == 1) ? 0 : 1;
        else if (v0)   g = 0;
        else if (v1)   g = 1;
        else           g = -1;
        exp_hz = (ra1 != 0 && m_busy[ra1]) || (ra2 != 0 && m_busy[ra2]);
        chk("req0_ready", req0_ready, g == 0);
        chk("req1_ready", req1_ready, g == 1);
        chk("hazard", hazard, exp_hz);
        chk("busy", busy, busy_vec());
        chk("rf_wa_hold", rf_wa, m_wa);
        chk("rf_wd_hold", rf_wd, m_wd);
        if (r) begin
            model_reset();
        end else begin
            if (m_pend_clr != 0) m_busy[m_pend_clr] = 1'b0;
            if (ss && sa != 0) m_busy[sa] = 1'b1;
            m_pend_clr = 0;
            if (g >= 0) begin
                wr_t w;
                w.a = (g == 0) ? a0[4:0] : a1[4:0];
                w.d = (g == 0) ? d0 : d1;
                w.due = cyc + 1;
                m_wa = w.a;
                m_wd = w.d;
                m_last = g;
                if (w.a != 5'd0) begin
                    m_pend_clr = w.a;
                    exp_q.push_back(w);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int ra1 = 0);
        int g;
        step(0, 0, 0, 32'd0, 0, 0, 32'd0, 0, 0, ra1, 0, g);
    endtask

    // Monitor: whenever a write is due the port must show it; otherwise idle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                wr_t w;
                w = exp_q.pop_front();
                chk("mon_rf_write", rf_write, 1'b1);
                chk("mon_rf_wa", rf_wa, w.a);
                chk("mon_rf_wd", rf_wd, w.d);
            end else begin
                chk("mon_rf_idle", rf_write, 1'b0);
            end
        end
    end

    int          g;
    int          grants[$];
    bit          p0, p1;
    int          pa0, pa1;
    logic [31:0] pd0, pd1;

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = 5'd0; req1_addr = 5'd0;
        req0_data = 32'd0; req1_data = 32'd0;
        sb_set = 1'b0; sb_addr = 5'd0; chk_ra1 = 5'd0; chk_ra2 = 5'd0;
        model_reset();
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // Reset state with no stimulus
        rst = 1'b0;
        #1;
        chk("rst_rf_write", rf_write, 1'b0);
        chk("rst_rf_wa", rf_wa, 5'd0);
        chk("rst_rf_wd", rf_wd, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_hazard", hazard, 1'b0);
        @(negedge clk);

        // Both valid from the first cycle: alternate 0,1,0,1,0,1
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 1, 32'h1111_1111, 1, 2, 32'h2222_2222, 0, 0, 0, 0, g);
            grants.push_back(g);
        end
        for (int i = 0; i < 6; i++) chk("alt_grant", grants[i], i % 2);
        idle();

        // Single write, then port idles
        step(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 32'd0, 0, 0, 0, 0, g);
        idle();
        idle();

        // Write to x0 consumed without a write; sb_set on x0 ignored
        step(0, 0, 0, 32'd0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, g);
        chk("x0_granted", g, 1);
        idle();
        step(0, 0, 0, 32'd0, 0, 0, 32'd0, 1, 0, 0, 0, g);
        idle();
        chk("x0_busy", busy, 32'd0);

        // Scoreboard: set 7, write 7, coincident re-set of 7
        step(0, 0, 0, 32'd0, 0, 0, 32'd0, 1, 7, 7, 0, g);
        idle(7);
        chk("sb7_hazard", hazard, 1'b1);
        step(0, 1, 7, 32'h0000_0777, 0, 0, 32'd0, 0, 0, 7, 0, g);   // accept edge E
        step(0, 0, 0, 32'd0, 0, 0, 32'd0, 1, 7, 7, 0, g);           // clear+set at E+1
        idle(7);
        chk("sb7_set_wins", busy[7], 1'b1);
        step(0, 1, 7, 32'h0000_0778, 0, 0, 32'd0, 0, 0, 7, 0, g);
        idle(7);
        idle(7);
        chk("sb7_cleared", hazard, 1'b0);

        // Reset right after a grant drops the loaded write and resets pointer
        step(0, 0, 0, 32'd0, 1, 3, 32'h3333_3333, 1, 9, 0, 0, g);
        step(1, 0, 0, 32'd0, 0, 0, 32'd0, 0, 0, 0, 0, g);
        chk("post_rst_write", rf_write, 1'b0);
        chk("post_rst_busy", busy, 32'd0);
        step(0, 1, 4, 32'h4444_4444, 1, 6, 32'h6666_6666, 0, 0, 0, 0, g);
        chk("post_rst_grant", g, 0);
        step(0, 0, 4, 32'h4444_4444, 1, 6, 32'h6666_6666, 0, 0, 0, 0, g);

        // Randomized traffic; a waiting requester holds its request stable
        p0 = 1'b0; p1 = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1'b1; pa0 = $urandom_range(0, 31); pd0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1'b1; pa1 = $urandom_range(0, 31); pd1 = $urandom;
            end
            step(($urandom_range(0, 99) == 0), p0, pa0, pd0, p1, pa1, pd1,
                 $urandom_range(0, 1), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), g);
            if (g == 0) p0 = 1'b0;
            if (g == 1) p1 = 1'b0;
        end

        idle();
        idle();
        idle();
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
